// File: rtl/mio_bus_arbiter.sv
// mio_bus_arbiter: shares the single MIO memory/IO bus between two masters.
//   Master 0 is normally the multi-cycle CPU, master 1 a DMA/VGA fetch engine.
//   One master is granted at a time. Its command is registered onto the slave
//   side, and it receives the read data plus a one-cycle ready pulse. A transfer
//   that hangs is aborted after TIMEOUT cycles.
//
// Parameters:
//   FIXED_PRIO  0 = round-robin on ties, 1 = master 0 always wins a tie
//   TIMEOUT     max XFER cycles before abort (1..65535), 0 disables the abort
//
// Ports:
//   clk, reset                 clock (rising edge), async active-low reset
//   m{0,1}_req/we/addr/wdata   master command inputs (req is a level)
//   m{0,1}_rdata/ready/err     read data, completion pulse, abort flag
//   s_req/we/addr/wdata        slave-side command (qualified by s_req)
//   s_rdata, s_ready           slave read data and completion
//   grant                      one-hot current owner, bit0 = master 0
//   busy                       high whenever a transfer is in progress
module mio_bus_arbiter #(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        m1_err,
  output logic        s_req,
  output logic        s_we,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,
  output logic [1:0]  grant,
  output logic        busy
);

  localparam bit          TimeoutEn   = (TIMEOUT != 0);
  localparam logic [15:0] TimeoutLast = 16'((TIMEOUT == 0) ? 32'd0 : TIMEOUT - 32'd1);

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e      state_q, state_d;
  logic        last_owner_q, last_owner_d;  // 0 = master 0, 1 = master 1
  logic [15:0] counter_q, counter_d;
  logic [1:0]  grant_q, grant_d;
  logic        s_we_q, s_we_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic        m0_ready_q, m0_ready_d, m1_ready_q, m1_ready_d;
  logic        m0_err_q, m0_err_d, m1_err_q, m1_err_d;

  logic        winner;     // 1 = master 1 wins this arbitration
  logic        done_now;
  logic        done_err;
  logic [31:0] done_data;

  always_comb begin
    if (m0_req && m1_req) begin
      winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_owner_q;
    end else begin
      winner = ~m0_req;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    counter_d    = counter_q;
    grant_d      = grant_q;
    s_we_d       = s_we_q;
    s_addr_d     = s_addr_q;
    s_wdata_d    = s_wdata_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    // Ready and err only live for the single DONE cycle.
    m0_ready_d   = 1'b0;
    m1_ready_d   = 1'b0;
    m0_err_d     = 1'b0;
    m1_err_d     = 1'b0;
    done_now     = 1'b0;
    done_err     = 1'b0;
    done_data    = 32'h0000_0000;

    case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          state_d      = StXfer;
          grant_d      = winner ? 2'b10 : 2'b01;
          last_owner_d = winner;
          counter_d    = 16'd0;
          s_we_d       = winner ? m1_we    : m0_we;
          s_addr_d     = winner ? m1_addr  : m0_addr;
          s_wdata_d    = winner ? m1_wdata : m0_wdata;
        end
      end
      StXfer: begin
        // A slave completion on the same edge as the timeout takes precedence.
        if (s_ready) begin
          done_now  = 1'b1;
          done_data = s_rdata;
        end else if (TimeoutEn && (counter_q == TimeoutLast)) begin
          done_now = 1'b1;
          done_err = 1'b1;
        end else begin
          counter_d = counter_q + 16'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end
      default: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end
    endcase

    if (done_now) begin
      state_d = StDone;
      if (grant_q[1]) begin
        m1_rdata_d = done_data;
        m1_ready_d = 1'b1;
        m1_err_d   = done_err;
      end else begin
        m0_rdata_d = done_data;
        m0_ready_d = 1'b1;
        m0_err_d   = done_err;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      last_owner_q <= 1'b1;
      counter_q    <= 16'd0;
      grant_q      <= 2'b00;
      s_we_q       <= 1'b0;
      s_addr_q     <= 32'h0000_0000;
      s_wdata_q    <= 32'h0000_0000;
      m0_rdata_q   <= 32'h0000_0000;
      m1_rdata_q   <= 32'h0000_0000;
      m0_ready_q   <= 1'b0;
      m1_ready_q   <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      counter_q    <= counter_d;
      grant_q      <= grant_d;
      s_we_q       <= s_we_d;
      s_addr_q     <= s_addr_d;
      s_wdata_q    <= s_wdata_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      m0_ready_q   <= m0_ready_d;
      m1_ready_q   <= m1_ready_d;
      m0_err_q     <= m0_err_d;
      m1_err_q     <= m1_err_d;
    end
  end

  // Decoded from state so that an asynchronous reset drops s_req at once.
  assign s_req    = (state_q == StXfer);
  assign busy     = (state_q != StIdle);
  assign grant    = grant_q;
  assign s_we     = s_we_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign m0_ready = m0_ready_q;
  assign m1_ready = m1_ready_q;
  assign m0_err   = m0_err_q;
  assign m1_err   = m1_err_q;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Testbench for mio_bus_arbiter. Two instances share all inputs:
//   index 0: round-robin, TIMEOUT=4; index 1: fixed priority, timeout disabled.
module tb_mio_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we, s_ready;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;

  logic [1:0]  grant_a [2];
  logic        busy_a [2], s_req_a [2], s_we_a [2];
  logic [31:0] s_addr_a [2], s_wdata_a [2], rdata0_a [2], rdata1_a [2];
  logic        ready0_a [2], ready1_a [2], err0_a [2], err1_a [2];

  mio_bus_arbiter #(.FIXED_PRIO(0), .TIMEOUT(4)) u_rr (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(rdata0_a[0]), .m0_ready(ready0_a[0]), .m0_err(err0_a[0]),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(rdata1_a[0]), .m1_ready(ready1_a[0]), .m1_err(err1_a[0]),
    .s_req(s_req_a[0]), .s_we(s_we_a[0]), .s_addr(s_addr_a[0]), .s_wdata(s_wdata_a[0]),
    .s_rdata(s_rdata), .s_ready(s_ready), .grant(grant_a[0]), .busy(busy_a[0])
  );

  mio_bus_arbiter #(.FIXED_PRIO(1), .TIMEOUT(0)) u_fp (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(rdata0_a[1]), .m0_ready(ready0_a[1]), .m0_err(err0_a[1]),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(rdata1_a[1]), .m1_ready(ready1_a[1]), .m1_err(err1_a[1]),
    .s_req(s_req_a[1]), .s_we(s_we_a[1]), .s_addr(s_addr_a[1]), .s_wdata(s_wdata_a[1]),
    .s_rdata(s_rdata), .s_ready(s_ready), .grant(grant_a[1]), .busy(busy_a[1])
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference state: last round-robin owner and each master's held read data.
  bit          lo;
  logic [31:0] exp_rd [2][2];  // [instance][master]

  typedef struct {
    bit          r0, r1;
    logic        we0, we1;
    logic [31:0] a0, a1, d0, d1, rd;
    int          w;          // XFER cycle index in which s_ready is driven high
    int          win_rr, win_fp;
    int          len_rr;     // XFER cycles seen by the TIMEOUT=4 instance
    bit          err_rr;
  } txn_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic txn_t predict(input txn_t t, input bit last);
    txn_t r = t;
    bit both = t.r0 && t.r1;
    r.win_rr = both ? (last ? 0 : 1) : (t.r0 ? 0 : 1);
    r.win_fp = both ? 0 : (t.r0 ? 0 : 1);
    r.len_rr = (t.w < 4) ? t.w + 1 : 4;
    r.err_rr = (t.w >= 4);
    return r;
  endfunction

  task automatic check_reset(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s s_req i%0d", tag, i), s_req_a[i], 0);
      chk($sformatf("%s busy i%0d", tag, i), busy_a[i], 0);
      chk($sformatf("%s grant i%0d", tag, i), grant_a[i], 0);
      chk($sformatf("%s ready i%0d", tag, i), {ready1_a[i], ready0_a[i]}, 0);
      chk($sformatf("%s err i%0d", tag, i), {err1_a[i], err0_a[i]}, 0);
      chk($sformatf("%s rdata0 i%0d", tag, i), rdata0_a[i], 0);
      chk($sformatf("%s rdata1 i%0d", tag, i), rdata1_a[i], 0);
      chk($sformatf("%s s_addr i%0d", tag, i), s_addr_a[i], 0);
      chk($sformatf("%s s_wdata i%0d", tag, i), s_wdata_a[i], 0);
      chk($sformatf("%s s_we i%0d", tag, i), s_we_a[i], 0);
    end
  endtask

  // Drives one arbitration from IDLE and checks every cycle until both are idle.
  task automatic run_txn(input txn_t t);
    int          win [2], len [2], maxlen;
    bit          err [2];
    logic        e_we [2];
    logic [31:0] e_a [2], e_d [2];
    win[0] = t.win_rr; win[1] = t.win_fp;
    len[0] = t.len_rr; len[1] = t.w + 1;
    err[0] = t.err_rr; err[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e_we[i] = (win[i] == 1) ? t.we1 : t.we0;
      e_a[i]  = (win[i] == 1) ? t.a1  : t.a0;
      e_d[i]  = (win[i] == 1) ? t.d1  : t.d0;
    end
    maxlen = (len[0] > len[1]) ? len[0] : len[1];
    m0_req = t.r0; m0_we = t.we0; m0_addr = t.a0; m0_wdata = t.d0;
    m1_req = t.r1; m1_we = t.we1; m1_addr = t.a1; m1_wdata = t.d1;
    s_ready = 1'b0;
    @(posedge clk); #1;
    // Master inputs change after the grant; the slave side must not follow.
    m0_req = 1'b0; m1_req = 1'b0;
    m0_we = ~t.we0; m1_we = ~t.we1;
    m0_addr = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
    lo = (t.win_rr == 1);
    for (int c = 0; c <= maxlen + 1; c++) begin
      s_ready = (c == t.w);
      s_rdata = (c == t.w) ? t.rd : $urandom;
      for (int i = 0; i < 2; i++) begin
        bit xfer = (c < len[i]);
        bit done = (c == len[i]);
        if (done) exp_rd[i][win[i]] = err[i] ? 32'h0 : t.rd;
        chk($sformatf("s_req i%0d c%0d", i, c), s_req_a[i], xfer);
        chk($sformatf("busy i%0d c%0d", i, c), busy_a[i], xfer || done);
        chk($sformatf("grant i%0d c%0d", i, c), grant_a[i],
            (xfer || done) ? ((win[i] == 1) ? 2'b10 : 2'b01) : 2'b00);
        chk($sformatf("m0_ready i%0d c%0d", i, c), ready0_a[i], done && win[i] == 0);
        chk($sformatf("m1_ready i%0d c%0d", i, c), ready1_a[i], done && win[i] == 1);
        chk($sformatf("m0_err i%0d c%0d", i, c), err0_a[i], done && win[i] == 0 && err[i]);
        chk($sformatf("m1_err i%0d c%0d", i, c), err1_a[i], done && win[i] == 1 && err[i]);
        chk($sformatf("m0_rdata i%0d c%0d", i, c), rdata0_a[i], exp_rd[i][0]);
        chk($sformatf("m1_rdata i%0d c%0d", i, c), rdata1_a[i], exp_rd[i][1]);
        chk($sformatf("s_we i%0d c%0d", i, c), s_we_a[i], e_we[i]);
        chk($sformatf("s_addr i%0d c%0d", i, c), s_addr_a[i], e_a[i]);
        chk($sformatf("s_wdata i%0d c%0d", i, c), s_wdata_a[i], e_d[i]);
      end
      @(posedge clk); #1;
    end
    s_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  txn_t        tbl [8];
  txn_t        t;
  logic [1:0]  gq [2][$];
  int unsigned rq;

  initial begin
    //        r0 r1 we0 we1 a0 a1 d0 d1 rd w | win_rr win_fp len_rr err_rr
    tbl[0] = '{1, 0, 0, 0, 32'h0000_0100, 32'h0, 32'h0, 32'h0, 32'h1234_5678, 0, 0, 0, 1, 0};
    tbl[1] = '{0, 1, 0, 1, 32'h0, 32'hE000_0000, 32'h0, 32'hA5A5_A5A5, 32'hDEAD_0001, 4,
               1, 1, 4, 1};
    tbl[2] = '{1, 1, 0, 0, 32'h10, 32'h20, 32'h0, 32'h0, 32'h0000_0B0B, 1, 0, 0, 2, 0};
    tbl[3] = '{1, 1, 1, 0, 32'h30, 32'h40, 32'h11, 32'h22, 32'hCAFE_F00D, 3, 1, 0, 4, 0};
    tbl[4] = '{1, 0, 0, 0, 32'h50, 32'h60, 32'h0, 32'h0, 32'h7777_7777, 6, 0, 0, 4, 1};
    tbl[5] = '{1, 1, 0, 1, 32'h70, 32'h80, 32'h33, 32'h44, 32'h0101_0101, 0, 1, 0, 1, 0};
    tbl[6] = '{0, 1, 0, 0, 32'h90, 32'hA0, 32'h0, 32'h0, 32'h5A5A_0000, 2, 1, 1, 3, 0};
    tbl[7] = '{1, 1, 1, 1, 32'hB0, 32'hC0, 32'h55, 32'h66, 32'h0F0F_0F0F, 5, 0, 0, 4, 1};

    reset = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    s_ready = 0; s_rdata = 0;
    lo = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_rd[i][0] = 32'h0; exp_rd[i][1] = 32'h0;
    end
    #3 check_reset("por");
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) run_txn(tbl[k]);

    // Both masters hold req through DONE; slave answers immediately.
    m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 1;
    m0_addr = 32'h1000; m1_addr = 32'h2000; s_ready = 1; s_rdata = 32'hC0DE_0042;
    @(posedge clk); #1;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 2; i++) if (s_req_a[i]) gq[i].push_back(grant_a[i]);
      if (c < 9) begin
        @(posedge clk); #1;
      end
    end
    m0_req = 0; m1_req = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    s_ready = 0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("contention grants i%0d", i), gq[i].size(), 4);
      chk($sformatf("contention idle i%0d", i), busy_a[i], 0);
      for (int k = 0; k < gq[i].size(); k++) begin
        if (i == 0) chk($sformatf("rr grant %0d", k), gq[i][k], ((!lo) ^ k[0]) ? 2'b10 : 2'b01);
        else        chk($sformatf("fp grant %0d", k), gq[i][k], 2'b01);
      end
    end
    exp_rd[0][0] = 32'hC0DE_0042; exp_rd[0][1] = 32'hC0DE_0042; exp_rd[1][0] = 32'hC0DE_0042;
    chk("rr m1 rdata after contention", rdata1_a[0], exp_rd[0][1]);
    chk("fp m1 rdata after contention", rdata1_a[1], exp_rd[1][1]);

    // Reset asserted in the second XFER cycle of a stalled transfer.
    m0_req = 1; m0_addr = 32'h3000; s_ready = 0;
    @(posedge clk); #1 m0_req = 0;
    @(posedge clk); #1;
    chk("pre-reset s_req", s_req_a[0], 1);
    #2 reset = 1'b0;
    #1 check_reset("midreset");
    @(posedge clk); #1;
    check_reset("heldreset");
    reset = 1'b1;
    lo = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_rd[i][0] = 32'h0; exp_rd[i][1] = 32'h0;
    end
    t = '{1, 1, 0, 1, 32'h4000, 32'h5000, 32'h0, 32'h99, 32'h8765_4321, 1, 0, 0, 0, 0};
    run_txn(predict(t, lo));

    for (int n = 0; n < 40; n++) begin
      rq = $urandom_range(1, 3);
      t.r0 = rq[0]; t.r1 = rq[1];
      t.we0 = 1'($urandom); t.we1 = 1'($urandom);
      t.a0 = $urandom; t.a1 = $urandom; t.d0 = $urandom; t.d1 = $urandom; t.rd = $urandom;
      t.w = int'($urandom_range(0, 6));
      run_txn(predict(t, lo));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
